// File: rtl/urna_arbitro_cabines.sv
// -----------------------------------------------------------------------------
// urna_arbitro_cabines
//   Shares one tally bank (C1..C4, Nulo) among N_CABINES voting booths. The
//   election moves through FECHADA -> ABERTA -> ENCERRADA. While it is open,
//   one booth per cycle is granted round-robin, and that booth's vote code
//   increments the matching tally.
//
// Optional feature (compile-time macro URNA_ARB_BRANCO_EN):
//   Adds a Branco tally output. Code 6 counts into Branco instead of Nulo.
//
// Parameters
//   N_CABINES  number of booths (2..8)
//   W_CONT     width of each tally counter (saturating)
//
// Ports
//   Clock       in   single clock, posedge
//   Reset       in   synchronous, active-high
//   Abrir       in   clear tallies and open the election (FECHADA/ENCERRADA)
//   Finish      in   close the election; has priority over Abrir
//   Req         in   per-booth vote request
//   Voto        in   per-booth 3-bit code, booth i = Voto[3i+2:3i]
//   Ack         out  one-cycle grant pulse, at most one bit set
//   C1..C4      out  candidate tallies (codes 0..3)
//   Nulo        out  null tally (codes 4..7, or 4,5,7 with Branco enabled)
//   Branco      out  blank tally (only with URNA_ARB_BRANCO_EN)
//   Status      out  1 while the election is open
//   dbg_estado  out  current FSM state (debug observation)
//
// Handshake: a booth raises Req with a stable Voto and holds both until it
// sees its Ack bit. It may drop Req one cycle after Ack. Because Ack is
// masked out of the eligible set, a Req that is still high during the Ack
// cycle is never granted twice in a row. A Req still held after that cycle
// is treated as a new vote.
// -----------------------------------------------------------------------------
module urna_arbitro_cabines #(
  parameter int N_CABINES = 4,
  parameter int W_CONT    = 8
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Abrir,
  input  logic                   Finish,
  input  logic [N_CABINES-1:0]   Req,
  input  logic [3*N_CABINES-1:0] Voto,
  output logic [N_CABINES-1:0]   Ack,
  output logic [W_CONT-1:0]      C1,
  output logic [W_CONT-1:0]      C2,
  output logic [W_CONT-1:0]      C3,
  output logic [W_CONT-1:0]      C4,
  output logic [W_CONT-1:0]      Nulo,
`ifdef URNA_ARB_BRANCO_EN
  output logic [W_CONT-1:0]      Branco,
`endif
  output logic                   Status,
  output logic [1:0]             dbg_estado
);

  localparam int PW = (N_CABINES > 1) ? $clog2(N_CABINES) : 1;

  typedef enum logic [1:0] {
    FECHADA   = 2'd0,
    ABERTA    = 2'd1,
    ENCERRADA = 2'd2
  } estado_t;

  estado_t           estado;
  logic [PW-1:0]     ptr;

  logic [N_CABINES-1:0] elig;
  logic                 found;
  logic [PW-1:0]        grant;
  logic [PW-1:0]        ptr_next;
  logic [2:0]           codigo;
  int                   idx;

  function automatic logic [W_CONT-1:0] sat_inc(input logic [W_CONT-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Round-robin search: the first eligible booth at or after ptr, with wrap.
  // The booth acked last cycle is excluded, so a late-falling Req is not
  // counted twice.
  always_comb begin
    elig  = Req & ~Ack;
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = 0; k < N_CABINES; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_CABINES) idx = idx - N_CABINES;
      if (!found && elig[idx]) begin
        found = 1'b1;
        grant = PW'(idx);
      end
    end
    codigo   = Voto[3*int'(grant) +: 3];
    ptr_next = (int'(grant) == N_CABINES - 1) ? '0 : PW'(int'(grant) + 1);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado <= FECHADA;
      ptr    <= '0;
      Ack    <= '0;
      C1     <= '0;
      C2     <= '0;
      C3     <= '0;
      C4     <= '0;
      Nulo   <= '0;
`ifdef URNA_ARB_BRANCO_EN
      Branco <= '0;
`endif
    end else begin
      Ack <= '0;
      case (estado)
        FECHADA, ENCERRADA: begin
          // Requests are ignored here. Opening clears the whole bank.
          if (Abrir && !Finish) begin
            estado <= ABERTA;
            C1     <= '0;
            C2     <= '0;
            C3     <= '0;
            C4     <= '0;
            Nulo   <= '0;
`ifdef URNA_ARB_BRANCO_EN
            Branco <= '0;
`endif
          end
        end
        ABERTA: begin
          // Abrir is ignored while open. Finish wins over a pending grant.
          if (Finish) begin
            estado <= ENCERRADA;
          end else if (found) begin
            Ack <= {{(N_CABINES-1){1'b0}}, 1'b1} << grant;
            ptr <= ptr_next;
            case (codigo)
              3'd0: C1 <= sat_inc(C1);
              3'd1: C2 <= sat_inc(C2);
              3'd2: C3 <= sat_inc(C3);
              3'd3: C4 <= sat_inc(C4);
`ifdef URNA_ARB_BRANCO_EN
              3'd6: Branco <= sat_inc(Branco);
`endif
              default: Nulo <= sat_inc(Nulo);
            endcase
          end
        end
        default: estado <= FECHADA;
      endcase
    end
  end

  assign Status     = (estado == ABERTA);
  assign dbg_estado = estado;

endmodule
